mem_ctrl: RTL and testbench

Memory controller answering the instruction-fetch port and the load/store port, and serialising each request onto the byte-wide, synchronous-read system RAM. Sits between the pipeline (IF stage, MEM stage) and the RAM/IO bus. Assembles 1/2/4-byte little-endian reads and splits writes into byte writes. Stalls IO writes while the IO buffer is full.

---
 rtl/mem_ctrl_pkg.sv | 43 ++++
 rtl/mem_ctrl_if.sv | 49 ++++
 rtl/mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, access-size codes, IO address select and the
// controller state encoding for the byte-serialising memory controller.
//   ADDR_W / DATA_W / BYTE_W : bus widths
//   SIZE_B / SIZE_H / SIZE_W : mem_size_i codes (1, 2, 4 bytes)
//   IO_ADDR_SEL              : value of address bits [17:16] selecting the IO sink
//   state_e / owner_e        : FSM state and current transfer owner
package mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] IO_ADDR_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Byte count for a size code; the unused code 2'b11 is treated as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [ADDR_W-1:0] addr);
    return addr[17:16] == IO_ADDR_SEL;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the fetch port, the load/store port and the byte-wide
// RAM/IO bus of mem_ctrl.
//   slave  : the controller's view (requests and RAM read data in, responses
//            and RAM address/write strobe out)
//   master : the environment's view (pipeline + RAM + IO sink)
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // fetch port
  logic              if_en_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rdy_o;
  logic [DATA_W-1:0] if_inst_o;

  // load/store port
  logic              mem_en_i;
  logic              mem_wr_i;
  logic [1:0]        mem_size_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_rdy_o;
  logic [DATA_W-1:0] mem_rdata_o;

  // RAM / IO bus
  logic [BYTE_W-1:0] ram_din_i;
  logic [BYTE_W-1:0] ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic              io_buffer_full_i;

  modport slave (
    input  if_en_i, if_addr_i,
    input  mem_en_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
    input  ram_din_i, io_buffer_full_i,
    output if_rdy_o, if_inst_o,
    output mem_rdy_o, mem_rdata_o,
    output ram_dout_o, ram_a_o, ram_wr_o
  );

  modport master (
    output if_en_i, if_addr_i,
    output mem_en_i, mem_wr_i, mem_size_i, mem_addr_i, mem_wdata_i,
    output ram_din_i, io_buffer_full_i,
    input  if_rdy_o, if_inst_o,
    input  mem_rdy_o, mem_rdata_o,
    input  ram_dout_o, ram_a_o, ram_wr_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetches and loads/stores onto a byte-wide,
// synchronous-read RAM. Reads of 1/2/4 bytes are assembled little-endian and
// zero-extended; writes are split into byte strobes. Writes to the IO window
// stall while the IO sink is full.
//   clk  : clock
//   rst  : synchronous active-high reset
//   rdy  : global enable; low freezes the controller
//   bus  : mem_ctrl_if.slave (fetch port, load/store port, RAM/IO bus)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  // control state
  state_e            state_q, state_d;
  logic [2:0]        ic_q, ic_d;        // bytes issued
  logic [2:0]        cc_q, cc_d;        // bytes captured
  logic              iss_q, iss_d;      // an address went out last cycle
  logic              if_rdy_q, if_rdy_d;
  logic              mem_rdy_q, mem_rdy_d;

  // transfer data
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] asm_q, asm_d;      // bytes assembled so far
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic [ADDR_W-1:0] issue_addr;
  logic              io_block;
  logic [DATA_W-1:0] asm_new;

  assign issue_addr = base_q + {{(ADDR_W-3){1'b0}}, ic_q};
  assign io_block   = is_io_addr(issue_addr) && bus.io_buffer_full_i;

  // RAM bus drive, decoded from the registered state
  always_comb begin
    bus.ram_a_o    = '0;
    bus.ram_wr_o   = 1'b0;
    bus.ram_dout_o = '0;
    case (state_q)
      ST_READ: begin
        if (ic_q < len_q) bus.ram_a_o = issue_addr;
      end
      ST_WRITE: begin
        bus.ram_a_o    = issue_addr;
        bus.ram_dout_o = wdata_q[{ic_q[1:0], 3'b000} +: BYTE_W];
        bus.ram_wr_o   = rdy && !io_block;
      end
      default: ;
    endcase
  end

  assign bus.if_rdy_o    = if_rdy_q;
  assign bus.if_inst_o   = if_inst_q;
  assign bus.mem_rdy_o   = mem_rdy_q;
  assign bus.mem_rdata_o = mem_rdata_q;

  // next-state and transfer bookkeeping
  always_comb begin
    state_d     = state_q;
    ic_d        = ic_q;
    cc_d        = cc_q;
    iss_d       = iss_q;
    if_rdy_d    = if_rdy_q;
    mem_rdy_d   = mem_rdy_q;
    owner_d     = owner_q;
    base_d      = base_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    asm_new = asm_q;
    asm_new[{cc_q[1:0], 3'b000} +: BYTE_W] = bus.ram_din_i;

    if (!rdy) begin
      // Frozen: the byte returning now is dropped, so rewind issue to capture
      // and let the missed byte be fetched again once enabled.
      if (state_q == ST_READ) begin
        ic_d  = cc_q;
        iss_d = 1'b0;
      end
    end else begin
      if_rdy_d  = 1'b0;
      mem_rdy_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A port's own rdy cycle blocks it, so only the other port may
          // start back-to-back; MEM wins ties.
          if (bus.mem_en_i && !mem_rdy_q) begin
            owner_d = OWN_MEM;
            base_d  = bus.mem_addr_i;
            len_d   = size_to_len(bus.mem_size_i);
            wdata_d = bus.mem_wdata_i;
            asm_d   = '0;
            ic_d    = '0;
            cc_d    = '0;
            iss_d   = 1'b0;
            state_d = bus.mem_wr_i ? ST_WRITE : ST_READ;
          end else if (bus.if_en_i && !if_rdy_q) begin
            owner_d = OWN_IF;
            base_d  = bus.if_addr_i;
            len_d   = 3'd4;
            asm_d   = '0;
            ic_d    = '0;
            cc_d    = '0;
            iss_d   = 1'b0;
            state_d = ST_READ;
          end
        end

        ST_READ: begin
          if (owner_q == OWN_IF &&
              (!bus.if_en_i || bus.if_addr_i != base_q)) begin
            // fetch redirected or withdrawn: drop it silently
            state_d = ST_IDLE;
            iss_d   = 1'b0;
          end else begin
            if (ic_q < len_q) begin
              ic_d  = 3'(ic_q + 3'd1);
              iss_d = 1'b1;
            end else begin
              iss_d = 1'b0;
            end
            if (iss_q) begin
              asm_d = asm_new;
              cc_d  = 3'(cc_q + 3'd1);
              if (3'(cc_q + 3'd1) == len_q) begin
                state_d = ST_IDLE;
                iss_d   = 1'b0;
                if (owner_q == OWN_IF) begin
                  if_inst_d = asm_new;
                  if_rdy_d  = 1'b1;
                end else begin
                  mem_rdata_d = asm_new;
                  mem_rdy_d   = 1'b1;
                end
              end
            end
          end
        end

        ST_WRITE: begin
          if (!io_block) begin
            ic_d = 3'(ic_q + 3'd1);
            if (ic_q == 3'(len_q - 3'd1)) begin
              state_d   = ST_IDLE;
              mem_rdy_d = 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ic_q        <= '0;
      cc_q        <= '0;
      iss_q       <= 1'b0;
      if_rdy_q    <= 1'b0;
      mem_rdy_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ic_q        <= ic_d;
      cc_q        <= cc_d;
      iss_q       <= iss_d;
      if_rdy_q    <= if_rdy_d;
      mem_rdy_q   <= mem_rdy_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // transfer-local data is always loaded before use, so it carries no reset
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    base_q  <= base_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte-wide synchronous RAM
// model. A table of load/store vectors plus hand-written sequences for fetch,
// arbitration, IO stall, fetch abort, global freeze and mid-transfer reset.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  mem_ctrl_if bus();

  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  // synchronous-read RAM, 64 KiB aliased over the address space
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
    if (bus.ram_wr_o) ram[bus.ram_a_o[15:0]] <= bus.ram_dout_o;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge (input drive point)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, ilat, nstr, strk, cnt, n;
    logic [31:0] d, id;

    for (int i = 0; i < 65536; i++) ram[i] <= 8'(i ^ (i >> 8));
    ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05;
    ram[16'h1002] <= 8'h10; ram[16'h1003] <= 8'h00;
    ram[16'h2000] <= 8'h67; ram[16'h2001] <= 8'h45;
    ram[16'h2002] <= 8'h23; ram[16'h2003] <= 8'h01;
    ram[16'h0007] <= 8'h9C;
    ram[16'h0040] <= 8'hAA; ram[16'h0043] <= 8'hBB;
    ram[16'h0000] <= 8'h5A;

    vecs[0] = '{1'b1, SIZE_W, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,          5};
    vecs[1] = '{1'b0, SIZE_W, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF,  6};
    vecs[2] = '{1'b0, SIZE_H, 32'h0000_0021, 32'h0,         32'h0000_ADBE,  4};
    vecs[3] = '{1'b0, SIZE_B, 32'h0000_0023, 32'h0,         32'h0000_00DE,  3};
    vecs[4] = '{1'b1, SIZE_H, 32'h0000_0041, 32'h1234_5678, 32'h0,          3};
    vecs[5] = '{1'b0, SIZE_W, 32'h0000_0040, 32'h0,         32'hBB56_78AA,  6};
    vecs[6] = '{1'b1, SIZE_B, 32'hFFFF_FFFF, 32'h0000_0041, 32'h0,          2};
    vecs[7] = '{1'b0, SIZE_H, 32'hFFFF_FFFF, 32'h0,         32'h0000_5A41,  4};

    rst = 1'b1; rdy = 1'b1;
    bus.if_en_i = 1'b0; bus.if_addr_i = '0;
    bus.mem_en_i = 1'b0; bus.mem_wr_i = 1'b0; bus.mem_size_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    bus.io_buffer_full_i = 1'b0;

    // reset state
    repeat (3) tick();
    #1;
    chk("rst_if_rdy",    32'(bus.if_rdy_o),   32'h0);
    chk("rst_mem_rdy",   32'(bus.mem_rdy_o),  32'h0);
    chk("rst_if_inst",   bus.if_inst_o,       32'h0);
    chk("rst_mem_rdata", bus.mem_rdata_o,     32'h0);
    chk("rst_ram_a",     bus.ram_a_o,         32'h0);
    chk("rst_ram_wr",    32'(bus.ram_wr_o),   32'h0);
    chk("rst_ram_dout",  32'(bus.ram_dout_o), 32'h0);
    tick(); rst = 1'b0;

    // IF fetch 0x1000
    tick();
    bus.if_en_i = 1'b1; bus.if_addr_i = 32'h1000;
    #1;
    ilat = 0; cnt = 0; id = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ilat != 0) bus.if_en_i = 1'b0;
      #1;
      if (k <= 4) chk($sformatf("if_addr_c%0d", k), bus.ram_a_o, 32'h1000 + 32'(k - 1));
      if (bus.if_rdy_o) begin
        cnt++;
        if (ilat == 0) begin ilat = k; id = bus.if_inst_o; end
      end
    end
    chk("if_lat",   32'(ilat), 32'd6);
    chk("if_inst",  id,        32'h0010_0513);
    chk("if_pulses", 32'(cnt), 32'd1);

    // table-driven loads/stores
    for (int v = 0; v < 8; v++) begin
      n = (vecs[v].size == SIZE_B) ? 1 : (vecs[v].size == SIZE_H) ? 2 : 4;
      tick();
      bus.mem_en_i = 1'b1; bus.mem_wr_i = vecs[v].wr; bus.mem_size_i = vecs[v].size;
      bus.mem_addr_i = vecs[v].addr; bus.mem_wdata_i = vecs[v].wdata;
      #1;
      lat = 0; nstr = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        tick(); #1;
        if (bus.ram_wr_o) begin
          chk($sformatf("v%0d_str%0d_addr", v, nstr), bus.ram_a_o, vecs[v].addr + 32'(nstr));
          chk($sformatf("v%0d_str%0d_data", v, nstr), 32'(bus.ram_dout_o),
              32'((vecs[v].wdata >> (8 * nstr)) & 32'hFF));
          nstr++;
        end
        if (bus.mem_rdy_o) lat = k;
      end
      tick();
      bus.mem_en_i = 1'b0;
      #1;
      chk($sformatf("v%0d_pulse_end", v), 32'(bus.mem_rdy_o), 32'h0);
      chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("v%0d_strobes", v), 32'(nstr), vecs[v].wr ? 32'(n) : 32'd0);
      if (!vecs[v].wr) chk($sformatf("v%0d_rdata", v), bus.mem_rdata_o, vecs[v].exp_rdata);
    end

    // IF and MEM raised together: MEM first, IF starts in MEM's rdy cycle
    tick();
    bus.if_en_i = 1'b1; bus.if_addr_i = 32'h1000;
    bus.mem_en_i = 1'b1; bus.mem_wr_i = 1'b0; bus.mem_size_i = SIZE_B; bus.mem_addr_i = 32'h7;
    #1;
    lat = 0; ilat = 0; d = '0; id = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (lat != 0) bus.mem_en_i = 1'b0;
      if (ilat != 0) bus.if_en_i = 1'b0;
      #1;
      if (bus.mem_rdy_o && lat == 0) begin lat = k; d = bus.mem_rdata_o; end
      if (bus.if_rdy_o && ilat == 0) begin ilat = k; id = bus.if_inst_o; end
    end
    chk("tie_mem_lat",  32'(lat),  32'd3);
    chk("tie_mem_data", d,         32'h0000_009C);
    chk("tie_if_lat",   32'(ilat), 32'd9);
    chk("tie_if_inst",  id,        32'h0010_0513);

    // store byte to IO window while the IO sink is full for 3 cycles
    tick();
    bus.mem_en_i = 1'b1; bus.mem_wr_i = 1'b1; bus.mem_size_i = SIZE_B;
    bus.mem_addr_i = 32'h0003_0000; bus.mem_wdata_i = 32'h41;
    bus.io_buffer_full_i = 1'b1;
    #1;
    lat = 0; nstr = 0; strk = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) bus.io_buffer_full_i = 1'b0;
      if (lat != 0) bus.mem_en_i = 1'b0;
      #1;
      if (bus.ram_wr_o) begin
        nstr++; strk = k;
        chk("io_addr", bus.ram_a_o, 32'h0003_0000);
        chk("io_data", 32'(bus.ram_dout_o), 32'h41);
      end
      if (bus.mem_rdy_o && lat == 0) lat = k;
    end
    chk("io_strobes",   32'(nstr), 32'd1);
    chk("io_strobe_cyc", 32'(strk), 32'd4);
    chk("io_lat",       32'(lat),  32'd5);

    // fetch redirected from 0x1000 to 0x2000 in c2
    tick();
    bus.if_en_i = 1'b1; bus.if_addr_i = 32'h1000;
    #1;
    ilat = 0; cnt = 0; id = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 2) bus.if_addr_i = 32'h2000;
      if (ilat != 0) bus.if_en_i = 1'b0;
      #1;
      if (bus.if_rdy_o) begin
        cnt++;
        if (ilat == 0) begin ilat = k; id = bus.if_inst_o; end
      end
    end
    chk("abort_pulses", 32'(cnt),  32'd1);
    chk("abort_lat",    32'(ilat), 32'd9);
    chk("abort_inst",   id,        32'h0123_4567);

    // rdy low in c3 and c4 of a word load
    tick();
    bus.mem_en_i = 1'b1; bus.mem_wr_i = 1'b0; bus.mem_size_i = SIZE_W; bus.mem_addr_i = 32'h1000;
    #1;
    lat = 0; nstr = 0; d = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      rdy = !(k == 3 || k == 4);
      if (lat != 0) bus.mem_en_i = 1'b0;
      #1;
      if (bus.ram_wr_o) nstr++;
      if (bus.mem_rdy_o && lat == 0) begin lat = k; d = bus.mem_rdata_o; end
    end
    chk("frz_no_wr", 32'(nstr), 32'd0);
    chk("frz_lat",   32'(lat),  32'd9);
    chk("frz_data",  d,         32'h0010_0513);

    // reset in the middle of a fetch abandons it
    tick();
    bus.if_en_i = 1'b1; bus.if_addr_i = 32'h1000;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.if_en_i = 1'b0;
    #1;
    cnt = 0;
    chk("mid_rst_ram_a", bus.ram_a_o, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      if (bus.if_rdy_o || bus.mem_rdy_o) cnt++;
    end
    chk("mid_rst_no_rdy", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
